axi_lite_cmd_master: RTL and testbench



---
 rtl/axi_lite_cmd_master.sv | 132 +++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: single-outstanding AXI4-Lite initiator driven by a valid/ready command port.
module axi_lite_cmd_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 11,
  parameter int C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_was_write,
  output logic                              busy,
  output logic                              timeout,
  output logic [15:0]                       err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;
  localparam logic [15:0] TO = 16'(C_TIMEOUT_CYCLES);
  state_t state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
  logic [15:0] cnt;
  logic cap, running;
  logic [1:0] cap_resp;
  assign cmd_ready = (state == IDLE) && !M_AXI_ARESET;
  assign busy = state != IDLE;
  assign M_AXI_AWADDR = addr;
  assign M_AXI_ARADDR = addr;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  always_comb begin
    cap = (state == WR_RESP && M_AXI_BVALID) || (state == RD_DATA && M_AXI_RVALID);
    cap_resp = state == WR_RESP ? M_AXI_BRESP : M_AXI_RRESP;
    running = state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
  end
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      timeout <= 1'b0;
      err_count <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
      rsp_was_write <= 1'b0;
      M_AXI_WDATA <= '0;
      M_AXI_WSTRB <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID <= 1'b0;
      M_AXI_BREADY <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY <= 1'b0;
    end else begin
      // the transaction keeps running past the timeout; only the sticky flag reports it
      if (running) begin
        if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        if (TO != 16'd0 && cnt + 16'd1 == TO) timeout <= 1'b1;
      end
      if (cap) begin
        rsp_valid <= 1'b1;
        rsp_resp <= cap_resp;
        rsp_was_write <= state == WR_RESP;
        rsp_rdata <= state == WR_RESP ? '0 : M_AXI_RDATA;
        if (cap_resp != 2'b00 && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
      case (state)
        IDLE: if (cmd_valid) begin
          addr <= cmd_addr;
          M_AXI_WDATA <= cmd_wdata;
          M_AXI_WSTRB <= cmd_wstrb;
          cnt <= '0;
          M_AXI_AWVALID <= cmd_write;
          M_AXI_WVALID <= cmd_write;
          M_AXI_ARVALID <= !cmd_write;
          state <= cmd_write ? WR_REQ : RD_REQ;
        end
        WR_REQ: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            M_AXI_BREADY <= 1'b1;
            state <= WR_RESP;
          end
        end
        WR_RESP: if (M_AXI_BVALID) begin
          M_AXI_BREADY <= 1'b0;
          state <= RESP;
        end
        RD_REQ: if (M_AXI_ARREADY) begin
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY <= 1'b1;
          state <= RD_DATA;
        end
        RD_DATA: if (M_AXI_RVALID) begin
          M_AXI_RREADY <= 1'b0;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: directed bench with a small AXI4-Lite slave model.
module tb_axi_lite_cmd_master;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [10:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0] cmd_wstrb = '0;
  logic cmd_ready, rsp_valid, rsp_was_write, busy, timeout;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [15:0] err_count;
  logic [10:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic aw_en = 1'b1, w_en = 1'b1, ar_en = 1'b1, b_en = 1'b1;
  logic [1:0] rresp_cfg = 2'b00;
  logic got_aw, got_w, bv, rv;
  logic [1:0] rresp;
  logic [10:0] waddr, a_eff;
  logic [31:0] wd, rd, d_eff;
  logic [31:0] mem [16];
  int aw_cnt = 0, w_cnt = 0;
  int total = 0, bad = 0;
  logic aw_hs, w_hs;
  logic [31:0] h_data;
  logic [1:0] h_resp;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(.C_TIMEOUT_CYCLES(8)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_was_write(rsp_was_write), .busy(busy),
    .timeout(timeout), .err_count(err_count),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(aw_en),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(w_en),
    .M_AXI_BRESP(2'b00), .M_AXI_BVALID(bv & b_en), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(ar_en),
    .M_AXI_RDATA(rd), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rv), .M_AXI_RREADY(rready)
  );

  assign aw_hs = awvalid && aw_en;
  assign w_hs = wvalid && w_en;
  assign a_eff = aw_hs ? awaddr : waddr;
  assign d_eff = w_hs ? wdata : wd;

  // slave: BVALID one cycle after both write handshakes, RVALID one cycle after AR handshake
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      got_aw <= 1'b0; got_w <= 1'b0; bv <= 1'b0; rv <= 1'b0;
    end else begin
      if (aw_hs) begin got_aw <= 1'b1; waddr <= awaddr; aw_cnt <= aw_cnt + 1; end
      if (w_hs) begin got_w <= 1'b1; wd <= wdata; w_cnt <= w_cnt + 1; end
      if ((got_aw || aw_hs) && (got_w || w_hs) && !bv) begin
        bv <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0;
        mem[a_eff[5:2]] <= d_eff;
      end
      if (bv && b_en && bready) bv <= 1'b0;
      if (arvalid && ar_en) begin rv <= 1'b1; rd <= mem[araddr[5:2]]; rresp <= rresp_cfg; end
      if (rv && rready) rv <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [10:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = 4'hF;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 0);
    chk("cmd_ready_back", 32'(cmd_ready), 1);
  endtask

  initial begin
    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_err", 32'(err_count), 0);
    @(posedge clk); #1 rst = 1'b0;
    step();
    chk("idle_cmd_ready", 32'(cmd_ready), 1);
    chk("prot", {26'd0, awprot, arprot}, 0);

    issue(1'b1, 11'h010, 32'hDEADBEEF);
    chk("wr_c1_aw", 32'(awvalid), 1);
    chk("wr_c1_w", 32'(wvalid), 1);
    chk("wr_c1_addr", 32'(awaddr), 32'h010);
    chk("wr_c1_busy", 32'(busy), 1);
    step();
    chk("wr_c2_bready", 32'(bready), 1);
    chk("wr_c2_aw", 32'(awvalid), 0);
    step();
    chk("wr_c3_rsp_valid", 32'(rsp_valid), 1);
    chk("wr_c3_resp", 32'(rsp_resp), 0);
    chk("wr_c3_rdata", rsp_rdata, 0);
    chk("wr_c3_was_write", 32'(rsp_was_write), 1);
    chk("wr_mem", mem[4], 32'hDEADBEEF);
    consume();

    issue(1'b0, 11'h010, 32'h0);
    chk("rd_c1_ar", 32'(arvalid), 1);
    chk("rd_c1_araddr", 32'(araddr), 32'h010);
    step();
    chk("rd_c2_rready", 32'(rready), 1);
    step();
    chk("rd_c3_rsp_valid", 32'(rsp_valid), 1);
    chk("rd_c3_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_c3_was_write", 32'(rsp_was_write), 0);
    consume();

    w_en = 1'b0;
    issue(1'b1, 11'h014, 32'h12345678);
    chk("dw_c1_both", {30'd0, awvalid, wvalid}, 3);
    step();
    chk("dw_c2_aw_w", {30'd0, awvalid, wvalid}, 1);
    chk("dw_c2_bready", 32'(bready), 0);
    step();
    chk("dw_c3_w", 32'(wvalid), 1);
    step();
    w_en = 1'b1;
    chk("dw_c4_w", 32'(wvalid), 1);
    chk("dw_c4_bready", 32'(bready), 0);
    step();
    w_en = 1'b0;
    chk("dw_c5_w", 32'(wvalid), 0);
    chk("dw_c5_bready", 32'(bready), 1);
    step();
    w_en = 1'b1;
    chk("dw_c6_rsp_valid", 32'(rsp_valid), 1);
    chk("dw_hs_aw", 32'(aw_cnt), 2);
    chk("dw_hs_w", 32'(w_cnt), 2);
    chk("dw_mem", mem[5], 32'h12345678);
    consume();

    rresp_cfg = 2'b10;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 11'h010, 32'h0);
      step();
      step();
      chk("er_rsp_valid", 32'(rsp_valid), 1);
      chk("er_resp", 32'(rsp_resp), 2);
      chk("er_count", 32'(err_count), 32'(i + 1));
      h_data = rsp_rdata; h_resp = rsp_resp;
      for (int j = 0; j < 5; j++) begin
        step();
        chk("er_stall", {rsp_valid, cmd_ready, rsp_resp, rsp_was_write, rsp_rdata[26:0]},
            {1'b1, 1'b0, h_resp, 1'b0, h_data[26:0]});
      end
      consume();
    end
    rresp_cfg = 2'b00;
    chk("er_total", 32'(err_count), 3);
    chk("to_clear_before", 32'(timeout), 0);

    ar_en = 1'b0;
    issue(1'b0, 11'h010, 32'h0);
    for (int k = 1; k < 8; k++) begin
      step();
      chk("to_not_yet", {30'd0, timeout, arvalid}, 1);
    end
    step();
    chk("to_set", {30'd0, timeout, arvalid}, 3);
    step();
    step();
    chk("to_ar_held", 32'(arvalid), 1);
    ar_en = 1'b1;
    step();
    ar_en = 1'b1;
    step();
    chk("to_rsp_valid", 32'(rsp_valid), 1);
    chk("to_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("to_sticky", 32'(timeout), 1);
    consume();

    b_en = 1'b0;
    issue(1'b1, 11'h018, 32'hCAFEF00D);
    step();
    step();
    chk("ar_pre_bready", 32'(bready), 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_bready", 32'(bready), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_err", 32'(err_count), 0);
    chk("ar_timeout", 32'(timeout), 0);
    chk("ar_cmd_ready", 32'(cmd_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    b_en = 1'b1;
    step();
    chk("ar_ready_after", 32'(cmd_ready), 1);
    issue(1'b0, 11'h014, 32'h0);
    chk("pr_c1_ar", 32'(arvalid), 1);
    step();
    chk("pr_c2_rsp_valid", 32'(rsp_valid), 0);
    step();
    chk("pr_c3_rsp_valid", 32'(rsp_valid), 1);
    chk("pr_c3_rdata", rsp_rdata, 32'h12345678);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
